// File: rtl/pov_pkg.sv
// Shared defaults for the POV column timing slice.
package pov_pkg;

  localparam int unsigned NUM_COLS   = 64;
  localparam int unsigned COL_W      = $clog2(NUM_COLS);
  localparam int unsigned PERIOD_W   = 28;
  localparam int unsigned MIN_PERIOD = 1000;
  localparam int unsigned MAX_PERIOD = 2**27;

endpackage

// File: rtl/pov_index_sync.sv
// Brings the raw encoder index into board_clk and turns each rising edge
// into a single-cycle idx_pulse, registered on the third edge after the rise.
module pov_index_sync (
  input  logic board_clk,
  input  logic Reset,
  input  logic index_in,
  output logic idx_pulse
);

  logic [2:0] sync_q;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      sync_q    <= '0;
      idx_pulse <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], index_in};
      idx_pulse <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/pov_column_timer.sv
// Measures the rotor period from the index pulse and spreads NUM_COLS column
// strobes evenly across each revolution using a Bresenham accumulator.
module pov_column_timer #(
  parameter int unsigned NUM_COLS   = pov_pkg::NUM_COLS,
  parameter int unsigned PERIOD_W   = pov_pkg::PERIOD_W,
  parameter int unsigned MIN_PERIOD = pov_pkg::MIN_PERIOD,
  parameter int unsigned MAX_PERIOD = pov_pkg::MAX_PERIOD
) (
  input  logic                        board_clk,
  input  logic                        Reset,
  input  logic                        index_in,
  input  logic                        enable,
  output logic                        col_strobe,
  output logic [$clog2(NUM_COLS)-1:0] col_idx,
  output logic [PERIOD_W-1:0]         rev_period,
  output logic                        locked,
  output logic                        timeout
);

  localparam int unsigned COL_W = $clog2(NUM_COLS);
  localparam int unsigned ACC_W = PERIOD_W + 1;

  localparam logic [PERIOD_W-1:0] CNT_MAX    = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] CNT_MIN    = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] CNT_ONE    = PERIOD_W'(1);
  localparam logic [ACC_W-1:0]    ACC_STEP   = ACC_W'(NUM_COLS);
  localparam logic [COL_W-1:0]    COL_PENULT = COL_W'(NUM_COLS - 2);
  localparam logic [COL_W-1:0]    COL_ONE    = COL_W'(1);

  logic                idx_pulse;
  logic [PERIOD_W-1:0] cnt;
  logic [ACC_W-1:0]    acc;
  logic                armed;
  logic                done;

  logic                cnt_sat;
  logic                arm_only;
  logic                accept;
  logic [ACC_W-1:0]    acc_sum;
  logic [ACC_W-1:0]    period_ext;
  logic                col_step;

  pov_index_sync u_index_sync (
    .board_clk (board_clk),
    .Reset     (Reset),
    .index_in  (index_in),
    .idx_pulse (idx_pulse)
  );

  // A stalled counter demotes any index edge to arm-only, so a stale period is never taken.
  always_comb begin
    cnt_sat    = (cnt == CNT_MAX);
    arm_only   = idx_pulse && (!armed || cnt_sat);
    accept     = idx_pulse && armed && !cnt_sat && (cnt >= CNT_MIN);
    acc_sum    = acc + ACC_STEP;
    period_ext = {1'b0, rev_period};
    col_step   = locked && !done && (acc_sum >= period_ext);
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      cnt        <= '0;
      acc        <= '0;
      armed      <= 1'b0;
      done       <= 1'b0;
      col_strobe <= 1'b0;
      col_idx    <= '0;
      rev_period <= '0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      col_strobe <= 1'b0;
      if (!cnt_sat) begin
        cnt <= cnt + CNT_ONE;
      end

      if (arm_only) begin
        armed <= 1'b1;
        cnt   <= CNT_ONE;
        if (cnt_sat) begin
          timeout <= 1'b1;
          locked  <= 1'b0;
        end
      end else if (accept) begin
        rev_period <= cnt;
        cnt        <= CNT_ONE;
        locked     <= 1'b1;
        timeout    <= 1'b0;
        acc        <= '0;
        col_idx    <= '0;
        done       <= 1'b0;
        col_strobe <= enable;
      end else if (cnt_sat) begin
        timeout <= 1'b1;
        locked  <= 1'b0;
        armed   <= 1'b0;
      end else if (locked && !done) begin
        // Glitch edges land here too, so the column sequence keeps running.
        if (col_step) begin
          acc        <= acc_sum - period_ext;
          col_idx    <= col_idx + COL_ONE;
          col_strobe <= enable;
          if (col_idx == COL_PENULT) begin
            done <= 1'b1;
          end
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_pov_column_timer.sv
// Bench for pov_column_timer: directed scenarios plus randomized spin rates,
// checked every cycle against an event-time model of the column schedule.
`timescale 1ns/1ps
module tb_pov_column_timer;

  localparam int unsigned N    = 8;
  localparam int unsigned MINP = 16;
  localparam int unsigned MAXP = 4096;
  localparam int unsigned PW   = 28;

  logic          board_clk = 1'b0;
  logic          Reset;
  logic          index_in;
  logic          enable;
  logic          col_strobe;
  logic [2:0]    col_idx;
  logic [PW-1:0] rev_period;
  logic          locked;
  logic          timeout;

  pov_column_timer #(
    .NUM_COLS   (N),
    .PERIOD_W   (PW),
    .MIN_PERIOD (MINP),
    .MAX_PERIOD (MAXP)
  ) dut (
    .board_clk  (board_clk),
    .Reset      (Reset),
    .index_in   (index_in),
    .enable     (enable),
    .col_strobe (col_strobe),
    .col_idx    (col_idx),
    .rev_period (rev_period),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 board_clk = ~board_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int hi_cnt   = 0;

  // Model: cycle numbers at which the DUT acts on each index edge, and strobe times.
  int pulses[$];
  int obs[$];
  bit m_armed, m_locked, m_timeout, m_strobe;
  int m_rev, m_ref, m_base, m_next, m_col;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit pulse;
    bit sat;
    int d;
    m_strobe = 1'b0;
    if (Reset) begin
      m_armed = 0; m_locked = 0; m_timeout = 0;
      m_rev = 0; m_col = 0; m_next = int'(N);
      m_ref = cyc;
      pulses.delete();
      return;
    end
    pulse = 1'b0;
    if (pulses.size() > 0 && pulses[0] == cyc) begin
      pulse = 1'b1;
      void'(pulses.pop_front());
    end
    d   = cyc - 1 - m_ref;
    sat = (d >= int'(MAXP));
    if (pulse && (!m_armed || sat)) begin
      m_armed = 1;
      m_ref   = cyc - 1;
      if (sat) begin
        m_timeout = 1;
        m_locked  = 0;
      end
    end else if (pulse && d >= int'(MINP)) begin
      m_rev     = d;
      m_ref     = cyc - 1;
      m_locked  = 1;
      m_timeout = 0;
      m_base    = cyc;
      m_col     = 0;
      m_next    = 1;
      m_strobe  = enable;
    end else if (sat) begin
      m_timeout = 1;
      m_locked  = 0;
      m_armed   = 0;
    end else if (m_locked && m_next < int'(N) &&
                 cyc == m_base + (m_next * m_rev + int'(N) - 1) / int'(N)) begin
      m_col    = m_next;
      m_next   = m_next + 1;
      m_strobe = enable;
    end
  endtask

  task automatic tick();
    @(posedge board_clk);
    cyc++;
    model_step();
    #1;
    check_val("col_strobe", col_strobe, m_strobe);
    check_val("col_idx", col_idx, m_col);
    check_val("rev_period", rev_period, m_rev);
    check_val("locked", locked, m_locked);
    check_val("timeout", timeout, m_timeout);
    if (col_strobe) obs.push_back(cyc);
    if (hi_cnt > 0) begin
      hi_cnt--;
      if (hi_cnt == 0) index_in = 1'b0;
    end
  endtask

  task automatic rise();
    index_in = 1'b1;
    hi_cnt   = 3;
    pulses.push_back(cyc + 4);
  endtask

  task automatic spin(input int p, input int revs);
    for (int r = 0; r < revs; r++) begin
      rise();
      repeat (p) tick();
    end
  endtask

  task automatic do_reset(input int hold);
    Reset    = 1'b1;
    index_in = 1'b0;
    hi_cnt   = 0;
    #1;
    check_val("rst_col_strobe", col_strobe, 0);
    check_val("rst_col_idx", col_idx, 0);
    check_val("rst_rev_period", rev_period, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_timeout", timeout, 0);
    repeat (hold) tick();
    Reset = 1'b0;
  endtask

  task automatic check_rev_strobes(input string tag, input int p);
    int gap_sum;
    check_val({tag, "_count"}, obs.size(), N);
    if (obs.size() == int'(N)) begin
      gap_sum = obs[N-1] - obs[0];
      check_val({tag, "_span"}, gap_sum, (int'(N - 1) * p + int'(N) - 1) / int'(N));
      for (int i = 1; i < int'(N); i++) begin
        check_val({tag, "_gap_ok"},
                  ((obs[i] - obs[i-1]) == p / int'(N)) ||
                  ((obs[i] - obs[i-1]) == p / int'(N) + 1), 1);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int c0;
    int p;
    int g;
    index_in = 1'b0;
    enable   = 1'b0;
    do_reset(3);
    enable = 1'b1;
    repeat (20) tick();

    // Steady spin at 800: first edge arms, second locks.
    obs.delete();
    spin(800, 1);
    check_val("arm_no_strobe", obs.size(), 0);
    obs.delete();
    rise();
    c0 = cyc;
    repeat (800) tick();
    check_val("lock_rev", rev_period, 800);
    check_val("lock_locked", locked, 1);
    check_val("first_strobe_lat", (obs.size() > 0) ? obs[0] - c0 : -1, 4);
    check_rev_strobes("steady800", 800);
    spin(800, 1);

    // Reset mid-revolution; the next edge only arms.
    rise();
    repeat (300) tick();
    do_reset(2);
    repeat (50) tick();
    obs.delete();
    spin(800, 1);
    check_val("post_rst_no_strobe", obs.size(), 0);
    check_val("post_rst_locked", locked, 0);
    spin(800, 1);
    check_val("relock_rev", rev_period, 800);

    // Non-divisible period.
    spin(803, 2);
    obs.delete();
    spin(803, 1);
    check_val("rev803", rev_period, 803);
    check_rev_strobes("p803", 803);

    // Glitch five clocks after an accepted edge.
    spin(800, 2);
    obs.delete();
    rise();
    repeat (5) tick();
    rise();
    repeat (795) tick();
    check_val("glitch_rev", rev_period, 800);
    check_rev_strobes("glitch", 800);
    spin(800, 1);
    check_val("glitch_next_rev", rev_period, 800);

    // Slowdown then speedup.
    obs.delete();
    spin(1600, 1);
    check_rev_strobes("slow", 800);
    check_val("slow_hold_idx", col_idx, 7);
    spin(400, 1);
    check_val("slow_rev", rev_period, 1600);
    rise();
    repeat (4) tick();
    check_val("speedup_idx", col_idx, 0);
    check_val("speedup_strobe", col_strobe, 1);
    repeat (396) tick();
    spin(400, 2);

    // Stall, then relock with strobes masked.
    enable = 1'b0;
    repeat (4200) tick();
    check_val("stall_timeout", timeout, 1);
    check_val("stall_locked", locked, 0);
    obs.delete();
    spin(800, 1);
    check_val("rearm_locked", locked, 0);
    spin(800, 1);
    check_val("relock2_locked", locked, 1);
    check_val("relock2_timeout", timeout, 0);
    check_val("masked_strobes", obs.size(), 0);
    check_val("masked_idx", col_idx, 7);
    enable = 1'b1;
    spin(800, 2);

    // Randomized spin rates, glitches and enable masking.
    for (int r = 0; r < 30; r++) begin
      p      = int'($urandom_range(200, 1300));
      enable = ($urandom_range(0, 4) != 0);
      rise();
      if ($urandom_range(0, 3) == 0) begin
        g = int'($urandom_range(5, p - 5));
        repeat (g) tick();
        rise();
        repeat (p - g) tick();
      end else begin
        repeat (p) tick();
      end
    end
    repeat (50) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
